// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 working-variable sequencer: state encoding,
// word width and the SHA-256 initial hash value.
package sha_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_LOAD    = 3'd2,
        ST_CALC    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [WORD_W-1:0] SHA256_H0 = 32'h6a09e667;
    localparam logic [WORD_W-1:0] SHA256_H1 = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] SHA256_H2 = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] SHA256_H3 = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] SHA256_H4 = 32'h510e527f;
    localparam logic [WORD_W-1:0] SHA256_H5 = 32'h9b05688c;
    localparam logic [WORD_W-1:0] SHA256_H6 = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] SHA256_H7 = 32'h5be0cd19;

    localparam logic [8*WORD_W-1:0] SHA256_IV = {
        SHA256_H0, SHA256_H1, SHA256_H2, SHA256_H3,
        SHA256_H4, SHA256_H5, SHA256_H6, SHA256_H7
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sha_var_sequencer.sv
// Streams eight 32-bit working variables A..H into a serial round core and collects
// its eight result words. Define SHA_SEQ_IV_EN to add use_iv (load the SHA-256 IV).
module sha_var_sequencer
    import sha_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CALC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef SHA_SEQ_IV_EN
    input  logic                  use_iv,
`endif
    input  logic [8*WORD_W-1:0]   state_in,
    input  logic [WORD_W-1:0]     out_var,
    output logic [WORD_W-1:0]     in_var,
    output logic                  busy,
    output logic                  done,
    output logic [8*WORD_W-1:0]   state_out
);

    localparam int CW = max3($clog2(WAIT_CYCLES + 1), $clog2(CALC_CYCLES + 1), 3);
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CALC_LAST = CW'((CALC_CYCLES == 0) ? 0 : CALC_CYCLES - 1);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [8*WORD_W-1:0]    shadow_q;
    logic [8*WORD_W-1:0]    state_out_q;
    logic [WORD_W-1:0]      in_var_q;
    logic                   busy_q;
    logic                   done_q;

    logic [8*WORD_W-1:0]    load_val;
    logic [2:0]             sel_idx;
    logic [WORD_W-1:0]      sel_word;

`ifdef SHA_SEQ_IV_EN
    assign load_val = use_iv ? SHA256_IV : state_in;
`else
    assign load_val = state_in;
`endif

    // in_var is registered, so it is loaded with the word for the *next* LOAD cycle.
    always_comb begin
        sel_idx = 3'd0;
        if (state_q == ST_LOAD) begin
            sel_idx = cnt_q[2:0] + 3'd1;
        end
    end

    // Word 0 (A) lives in the top bits, so the word index maps to offset (7-idx)*32.
    assign sel_word = shadow_q[{~sel_idx, 5'b0} +: WORD_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            state_out_q <= '0;
            in_var_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    in_var_q <= '0;
                    if (start) begin
                        shadow_q <= load_val;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        if (WAIT_CYCLES == 0) begin
                            state_q  <= ST_LOAD;
                            in_var_q <= load_val[8*WORD_W-1 -: WORD_W];
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= ST_LOAD;
                        in_var_q <= sel_word;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_q    <= '0;
                        in_var_q <= '0;
                        state_q  <= (CALC_CYCLES == 0) ? ST_CAPTURE : ST_CALC;
                    end else begin
                        cnt_q    <= cnt_q + 1'b1;
                        in_var_q <= sel_word;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == CALC_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state_out_q[{~cnt_q[2:0], 5'b0} +: WORD_W] <= out_var;
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_var    = in_var_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_sha_var_sequencer.sv
// Randomized self-checking bench: two sequencer instances (default timing and
// WAIT=0/CALC=3) run in lockstep against a cycle-indexed reference model.
module tb_sha_var_sequencer;

    localparam int W0 = 2;
    localparam int C0 = 1;
    localparam int W1 = 0;
    localparam int C1 = 3;
    localparam int LAT = W0 + 8 + C0 + 8 + 1;     // same for both instances
    localparam int CAP_FIRST = W0 + C0 + 9;        // edge index of first captured word

    logic         clk;
    logic         reset;
    logic         start;
    logic         use_iv;
    logic [255:0] state_in;
    logic [31:0]  out_var;

    logic [31:0]  in_var0, in_var1;
    logic         busy0, busy1, done0, done1;
    logic [255:0] state_out0, state_out1;

    int n_checks;
    int n_pass;

    logic [255:0] prev_out;
    logic [255:0] iv_ref;
    logic [255:0] seq_ref;

    sha_var_sequencer #(.WAIT_CYCLES(W0), .CALC_CYCLES(C0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef SHA_SEQ_IV_EN
        .use_iv    (use_iv),
`endif
        .state_in  (state_in),
        .out_var   (out_var),
        .in_var    (in_var0),
        .busy      (busy0),
        .done      (done0),
        .state_out (state_out0)
    );

    sha_var_sequencer #(.WAIT_CYCLES(W1), .CALC_CYCLES(C1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef SHA_SEQ_IV_EN
        .use_iv    (use_iv),
`endif
        .state_in  (state_in),
        .out_var   (out_var),
        .in_var    (in_var1),
        .busy      (busy1),
        .done      (done1),
        .state_out (state_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) begin
            v[32*k +: 32] = $urandom;
        end
        return v;
    endfunction

    // Word j of a {A..H} vector, A = word 0 in the top bits.
    function automatic logic [31:0] word_of(input logic [255:0] v, input int j);
        logic [255:0] s;
        s = v >> (32 * (7 - j));
        return s[31:0];
    endfunction

    function automatic logic [31:0] exp_in_var(input logic [255:0] ld, input int wait_c, input int t);
        int j;
        j = t - 1 - wait_c;
        if (j >= 0 && j < 8) return word_of(ld, j);
        return 32'h0;
    endfunction

    // One complete transaction. Cycle t observes outputs right after edge E(t-1),
    // where E0 is the edge that accepts start; hist[k] is out_var present at edge Ek.
    task automatic run_txn(input string name, input logic [255:0] sv, input logic [255:0] exp_load,
                           input logic iv_sel, input int repulse_t, input bit seq_ov);
        logic [31:0]  hist [0:24];
        logic [255:0] exp_new;
        exp_new = '0;
        @(negedge clk);
        start    = 1'b1;
        state_in = sv;
        use_iv   = iv_sel;
        out_var  = $urandom;
        hist[0]  = out_var;
        for (int t = 1; t <= LAT + 3; t++) begin
            @(negedge clk);
            check($sformatf("%s in_var0 t%0d", name, t), {224'h0, in_var0}, {224'h0, exp_in_var(exp_load, W0, t)});
            check($sformatf("%s in_var1 t%0d", name, t), {224'h0, in_var1}, {224'h0, exp_in_var(exp_load, W1, t)});
            check($sformatf("%s busy t%0d", name, t), {254'h0, busy1, busy0}, {254'h0, {2{t <= LAT}}});
            check($sformatf("%s done t%0d", name, t), {254'h0, done1, done0}, {254'h0, {2{t == LAT + 1}}});
            if (t == 1 || t == CAP_FIRST) begin
                check($sformatf("%s hold0 t%0d", name, t), state_out0, prev_out);
                check($sformatf("%s hold1 t%0d", name, t), state_out1, prev_out);
            end
            if (t >= LAT) begin
                check($sformatf("%s out0 t%0d", name, t), state_out0, exp_new);
                check($sformatf("%s out1 t%0d", name, t), state_out1, exp_new);
            end
            start    = (t == repulse_t);
            state_in = rand256();
            use_iv   = 1'($urandom);
            if (seq_ov && t >= CAP_FIRST && t < CAP_FIRST + 8) out_var = 32'(t - CAP_FIRST + 1);
            else out_var = $urandom;
            hist[t] = out_var;
            if (t == CAP_FIRST + 7) begin
                for (int k = 0; k < 8; k++) exp_new[32*(7-k) +: 32] = hist[CAP_FIRST + k];
            end
        end
        start = 1'b0;
        prev_out = exp_new;
        $display("txn %s: load=%h result=%h", name, exp_load, exp_new);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        use_iv   = 1'b0;
        state_in = '0;
        out_var  = '0;
        prev_out = '0;
        iv_ref   = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
        seq_ref  = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;

        repeat (2) @(negedge clk);
        check("reset in_var", {224'h0, in_var0 | in_var1}, 256'h0);
        check("reset flags", {252'h0, busy0, busy1, done0, done1}, 256'h0);
        check("reset state_out", state_out0 | state_out1, 256'h0);
        reset = 1'b1;
        $display("txn reset: released");

        run_txn("iv_load", iv_ref, iv_ref, 1'b0, 0, 1'b0);

        begin
            logic [255:0] v;
            v = rand256();
            run_txn("loopback", v, v, 1'b0, 0, 1'b1);
            check("loopback const0", state_out0, seq_ref);
            check("loopback const1", state_out1, seq_ref);
        end

        begin
            logic [255:0] v;
            v = rand256();
            run_txn("repulse_calc", v, v, 1'b0, W0 + 9, 1'b0);
        end

        for (int n = 0; n < 4; n++) begin
            logic [255:0] v;
            v = rand256();
            run_txn($sformatf("rand%0d", n), v, v, 1'b0, int'($urandom_range(19, 0)), 1'b0);
        end

        // Abort mid-LOAD while dut0 is driving word C.
        begin
            logic [255:0] v;
            v = rand256();
            @(negedge clk);
            start    = 1'b1;
            state_in = v;
            use_iv   = 1'b0;
            for (int t = 1; t <= W0 + 3; t++) begin
                @(negedge clk);
                start    = 1'b0;
                state_in = rand256();
            end
            check("abort word C", {224'h0, in_var0}, {224'h0, word_of(v, 2)});
            #2 reset = 1'b0;
            #1;
            check("abort in_var", {224'h0, in_var0 | in_var1}, 256'h0);
            check("abort flags", {252'h0, busy0, busy1, done0, done1}, 256'h0);
            check("abort state_out", state_out0 | state_out1, 256'h0);
            @(negedge clk);
            reset    = 1'b1;
            prev_out = '0;
            $display("txn abort: reset mid-load");
        end

        begin
            logic [255:0] v;
            v = rand256();
            run_txn("after_abort", v, v, 1'b0, 0, 1'b0);
        end

`ifdef SHA_SEQ_IV_EN
        run_txn("use_iv", {256{1'b1}}, iv_ref, 1'b1, 0, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
